intersection_phase_scheduler: RTL and testbench

//   Phase sequencer for a two-road (NS/EW) intersection. It drives both signal heads, all-red

---
 rtl/intersection_phase_scheduler.sv | 223 ++++++++++++++++++++++
 tb/tb_intersection_phase_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler
//   Two-road (NS/EW) intersection phase sequencer with all-red clearance,
//   latched pedestrian walk requests and a seconds-remaining export for the
//   countdown display.
//   Optional feature macro: EMERG_PREEMPT_EN enables emergency preemption
//   (EMERG state, phase code 6). Without it emerg_req is ignored and code 6
//   is treated as an illegal state.
module intersection_phase_scheduler #(
   parameter int CLK_FREQ      = 50_000_000,
   parameter int NS_GREEN_TIME = 30,
   parameter int EW_GREEN_TIME = 25,
   parameter int YELLOW_TIME   = 5,
   parameter int ALL_RED_TIME  = 2,
   parameter int PED_TIME      = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ped_req_ns,
   input  logic       ped_req_ew,
   input  logic       emerg_req,
   output logic       ns_r,
   output logic       ns_y,
   output logic       ns_g,
   output logic       ew_r,
   output logic       ew_y,
   output logic       ew_g,
   output logic       walk_ns,
   output logic       walk_ew,
   output logic       ped_wait_ns,
   output logic       ped_wait_ew,
   output logic [2:0] phase,
   output logic [5:0] remain
);

   localparam int            CW        = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
   localparam logic [CW-1:0] TICK_LAST = CW'(CLK_FREQ - 1);

   localparam logic [5:0] T_NS      = 6'(NS_GREEN_TIME);
   localparam logic [5:0] T_EW      = 6'(EW_GREEN_TIME);
   localparam logic [5:0] T_Y       = 6'(YELLOW_TIME);
   localparam logic [5:0] T_AR      = 6'(ALL_RED_TIME);
   // A granted walk stretches the green to at least the pedestrian time.
   localparam logic [5:0] T_NS_WALK = 6'((NS_GREEN_TIME > PED_TIME) ? NS_GREEN_TIME : PED_TIME);
   localparam logic [5:0] T_EW_WALK = 6'((EW_GREEN_TIME > PED_TIME) ? EW_GREEN_TIME : PED_TIME);

`ifdef EMERG_PREEMPT_EN
   localparam logic EMERG_EN = 1'b1;
`else
   localparam logic EMERG_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_NS_GREEN  = 3'd0,
      S_NS_YELLOW = 3'd1,
      S_ALL_RED_A = 3'd2,
      S_EW_GREEN  = 3'd3,
      S_EW_YELLOW = 3'd4,
      S_ALL_RED_B = 3'd5,
      S_EMERG     = 3'd6,
      S_ILLEGAL   = 3'd7
   } state_t;

   logic [CW-1:0] tick_cnt;
   logic          sec_tick;
   logic          last_sec;
   logic          emerg_active;

   state_t     state_q, state_d;
   logic [5:0] remain_q, remain_d;
   logic       walk_ns_d, walk_ew_d;
   logic       ped_wait_ns_d, ped_wait_ew_d;
   logic [2:0] ns_lamp_d, ew_lamp_d;   // {r, y, g}

   assign sec_tick     = (tick_cnt == TICK_LAST);
   assign last_sec     = sec_tick && (remain_q <= 6'd1);
   // Ties off to zero in the default build, so preemption paths are pruned.
   assign emerg_active = emerg_req & EMERG_EN;

   assign phase  = state_q;
   assign remain = remain_q;

   // Free-running one-second tick counter; never realigned to phase changes.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples
      // pre-edge values, independent of statement order.
      if (!rst_n)
         tick_cnt <= '0;
      else if (sec_tick)
         tick_cnt <= '0;
      else
         tick_cnt <= tick_cnt + CW'(1);
   end

   // Next-state, countdown, pedestrian and lamp decode.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a value unassigned and no latch is inferred.
      state_d       = state_q;
      remain_d      = sec_tick ? (remain_q - 6'd1) : remain_q;
      walk_ns_d     = walk_ns;
      walk_ew_d     = walk_ew;
      ped_wait_ns_d = ped_wait_ns | ped_req_ns;
      ped_wait_ew_d = ped_wait_ew | ped_req_ew;

      case (state_q)
         S_NS_GREEN: begin
            if (emerg_active || last_sec) begin
               state_d   = S_NS_YELLOW;
               remain_d  = T_Y;
               walk_ns_d = 1'b0;
            end
         end
         S_NS_YELLOW: begin
            if (last_sec) begin
               state_d  = S_ALL_RED_A;
               remain_d = T_AR;
            end
         end
         S_ALL_RED_A: begin
            if (last_sec) begin
               if (emerg_active) begin
                  state_d  = S_EMERG;
                  remain_d = 6'd0;
               end else begin
                  state_d = S_EW_GREEN;
                  // Entry edge: clear the grant, re-latch a request still held.
                  if (ped_wait_ew) begin
                     walk_ew_d     = 1'b1;
                     ped_wait_ew_d = ped_req_ew;
                     remain_d      = T_EW_WALK;
                  end else begin
                     remain_d = T_EW;
                  end
               end
            end
         end
         S_EW_GREEN: begin
            if (emerg_active || last_sec) begin
               state_d   = S_EW_YELLOW;
               remain_d  = T_Y;
               walk_ew_d = 1'b0;
            end
         end
         S_EW_YELLOW: begin
            if (last_sec) begin
               state_d  = S_ALL_RED_B;
               remain_d = T_AR;
            end
         end
         S_ALL_RED_B: begin
            if (last_sec) begin
               if (emerg_active) begin
                  state_d  = S_EMERG;
                  remain_d = 6'd0;
               end else begin
                  state_d = S_NS_GREEN;
                  if (ped_wait_ns) begin
                     walk_ns_d     = 1'b1;
                     ped_wait_ns_d = ped_req_ns;
                     remain_d      = T_NS_WALK;
                  end else begin
                     remain_d = T_NS;
                  end
               end
            end
         end
`ifdef EMERG_PREEMPT_EN
         S_EMERG: begin
            remain_d = 6'd0;
            if (!emerg_req) begin
               state_d  = S_ALL_RED_B;
               remain_d = T_AR;
            end
         end
`endif
         default: begin
            // Illegal code: fall back to the safe all-red clearance.
            state_d   = S_ALL_RED_B;
            remain_d  = T_AR;
            walk_ns_d = 1'b0;
            walk_ew_d = 1'b0;
         end
      endcase

      // Lamps follow the state being entered, so they update with it.
      ns_lamp_d = 3'b100;
      ew_lamp_d = 3'b100;
      case (state_d)
         S_NS_GREEN:  ns_lamp_d = 3'b001;
         S_NS_YELLOW: ns_lamp_d = 3'b010;
         S_EW_GREEN:  ew_lamp_d = 3'b001;
         S_EW_YELLOW: ew_lamp_d = 3'b010;
         default: begin
            ns_lamp_d = 3'b100;
            ew_lamp_d = 3'b100;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= S_ALL_RED_B;
         remain_q         <= T_AR;
         walk_ns          <= 1'b0;
         walk_ew          <= 1'b0;
         ped_wait_ns      <= 1'b0;
         ped_wait_ew      <= 1'b0;
         {ns_r, ns_y, ns_g} <= 3'b100;
         {ew_r, ew_y, ew_g} <= 3'b100;
      end else begin
         state_q          <= state_d;
         remain_q         <= remain_d;
         walk_ns          <= walk_ns_d;
         walk_ew          <= walk_ew_d;
         ped_wait_ns      <= ped_wait_ns_d;
         ped_wait_ew      <= ped_wait_ew_d;
         {ns_r, ns_y, ns_g} <= ns_lamp_d;
         {ew_r, ew_y, ew_g} <= ew_lamp_d;
      end
   end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// tb_intersection_phase_scheduler
//   Directed bench for intersection_phase_scheduler with CLK_FREQ=10,
//   NS_G=5, EW_G=4, Y=2, AR=1, PED=7. Outputs are sampled on the falling
//   edge. The emergency scenario runs when EMERG_PREEMPT_EN is defined,
//   otherwise the emerg_req-ignored scenario runs.
module tb_intersection_phase_scheduler;

   localparam int CLK_FREQ = 10;
   localparam int NS_G     = 5;
   localparam int EW_G     = 4;
   localparam int Y_T      = 2;
   localparam int AR_T     = 1;
   localparam int PED_T    = 7;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ped_req_ns, ped_req_ew, emerg_req;
   logic       ns_r, ns_y, ns_g, ew_r, ew_y, ew_g;
   logic       walk_ns, walk_ew, ped_wait_ns, ped_wait_ew;
   logic [2:0] phase;
   logic [5:0] remain;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   intersection_phase_scheduler #(
      .CLK_FREQ      (CLK_FREQ),
      .NS_GREEN_TIME (NS_G),
      .EW_GREEN_TIME (EW_G),
      .YELLOW_TIME   (Y_T),
      .ALL_RED_TIME  (AR_T),
      .PED_TIME      (PED_T)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ped_req_ns  (ped_req_ns),
      .ped_req_ew  (ped_req_ew),
      .emerg_req   (emerg_req),
      .ns_r        (ns_r),
      .ns_y        (ns_y),
      .ns_g        (ns_g),
      .ew_r        (ew_r),
      .ew_y        (ew_y),
      .ew_g        (ew_g),
      .walk_ns     (walk_ns),
      .walk_ew     (walk_ew),
      .ped_wait_ns (ped_wait_ns),
      .ped_wait_ew (ped_wait_ew),
      .phase       (phase),
      .remain      (remain)
   );

   // Expected {ns_r,ns_y,ns_g,ew_r,ew_y,ew_g} for a phase code.
   function automatic logic [5:0] exp_heads(input int ph);
      logic [2:0] ns, ew;
      ns = (ph == 0) ? 3'b001 : (ph == 1) ? 3'b010 : 3'b100;
      ew = (ph == 3) ? 3'b001 : (ph == 4) ? 3'b010 : 3'b100;
      return {ns, ew};
   endfunction

   // One clock, then sample on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n      = 1'b0;
      ped_req_ns = 1'b0;
      ped_req_ew = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Bounded wait for a phase code; an expired budget counts as a failure.
   task automatic wait_phase(input logic [2:0] ph, input int budget, input string tag);
      int n;
      n = 0;
      while (phase !== ph && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (phase !== ph) begin
         failures++;
         $display("FAIL %s: wait for phase %0d timed out, phase=%0d", tag, ph, phase);
      end
   endtask

   task automatic test_reset();
      emerg_req  = 1'b0;
      ped_req_ns = 1'b0;
      ped_req_ew = 1'b0;
      rst_n      = 1'b0;
      #12;
      checks++;
      if ({phase, remain} !== {3'd5, 6'd1}) begin
         failures++;
         $display("FAIL reset_state: phase/remain=%0d/%0d want 5/1", phase, remain);
      end
      checks++;
      if ({ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk_ns, walk_ew, ped_wait_ns, ped_wait_ew}
          !== 10'b100_100_0000) begin
         failures++;
         $display("FAIL reset_lamps: got %b want 1001000000",
                  {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk_ns, walk_ew, ped_wait_ns, ped_wait_ew});
      end
   endtask

   // Full cycle after reset; every sample checks phase, remain, heads, walk.
   task automatic test_normal_cycle(input logic emerg, input string tag);
      int seg_ph [8] = '{5, 0, 1, 2, 3, 4, 5, 0};
      int seg_t  [8] = '{AR_T, NS_G, Y_T, AR_T, EW_G, Y_T, AR_T, NS_G};
      logic [16:0] obs, exp_v;
      emerg_req = emerg;
      do_reset();
      for (int s = 0; s < 8; s++) begin
         for (int r = seg_t[s]; r >= 1; r--) begin
            for (int k = 0; k < CLK_FREQ; k++) begin
               exp_v = {3'(seg_ph[s]), 6'(r), exp_heads(seg_ph[s]), 2'b00};
               obs   = {phase, remain, ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk_ns, walk_ew};
               checks++;
               if (obs !== exp_v) begin
                  failures++;
                  $display("FAIL %s seg%0d r%0d k%0d: got %b want %b", tag, s, r, k, obs, exp_v);
               end
               step();
            end
         end
      end
      emerg_req = 1'b0;
   endtask

   // NS request made during EW_GREEN is served at the next NS_GREEN.
   task automatic test_ped_between();
      int cnt;
      emerg_req = 1'b0;
      do_reset();
      wait_phase(3'd3, 200, "ped_between_ew");
      repeat (3) step();
      ped_req_ns = 1'b1;
      step();
      ped_req_ns = 1'b0;
      checks++;
      if ({ped_wait_ns, walk_ns} !== 2'b10) begin
         failures++;
         $display("FAIL ped_latch: wait/walk=%b want 10", {ped_wait_ns, walk_ns});
      end
      wait_phase(3'd0, 300, "ped_between_ns");
      checks++;
      if ({walk_ns, ped_wait_ns, remain} !== {2'b10, 6'd7}) begin
         failures++;
         $display("FAIL ped_grant: walk/wait=%b remain=%0d want 10 / 7",
                  {walk_ns, ped_wait_ns}, remain);
      end
      cnt = 0;
      while (phase === 3'd0 && cnt < 200) begin
         cnt++;
         step();
      end
      checks++;
      if (cnt !== 70) begin
         failures++;
         $display("FAIL ped_green_len: got %0d clk want 70", cnt);
      end
      checks++;
      if ({phase, walk_ns} !== {3'd1, 1'b0}) begin
         failures++;
         $display("FAIL ped_walk_clear: phase=%0d walk_ns=%b want 1/0", phase, walk_ns);
      end
   endtask

   // Request during NS_GREEN is deferred; request held over entry re-latches.
   task automatic test_ped_during_green();
      int   cnt;
      logic saw_walk;
      wait_phase(3'd0, 300, "ped_green_entry");
      checks++;
      if ({walk_ns, remain} !== {1'b0, 6'd5}) begin
         failures++;
         $display("FAIL green_plain_entry: walk=%b remain=%0d want 0/5", walk_ns, remain);
      end
      cnt      = 0;
      saw_walk = 1'b0;
      while (phase === 3'd0 && cnt < 200) begin
         ped_req_ns = (cnt == 0);
         if (walk_ns) saw_walk = 1'b1;
         cnt++;
         step();
      end
      ped_req_ns = 1'b0;
      checks++;
      if ({cnt, saw_walk, ped_wait_ns} !== {32'd50, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL green_defer: len=%0d saw_walk=%b wait=%b want 50/0/1",
                  cnt, saw_walk, ped_wait_ns);
      end
      wait_phase(3'd5, 300, "relatch_ar");
      ped_req_ns = 1'b1;
      wait_phase(3'd0, 50, "relatch_ns");
      ped_req_ns = 1'b0;
      checks++;
      if ({walk_ns, ped_wait_ns, remain} !== {2'b11, 6'd7}) begin
         failures++;
         $display("FAIL entry_relatch: walk/wait=%b remain=%0d want 11 / 7",
                  {walk_ns, ped_wait_ns}, remain);
      end
   endtask

   // Asynchronous reset in the middle of a walk-extended EW_GREEN.
   task automatic test_reset_mid_walk();
      ped_req_ew = 1'b1;
      step();
      ped_req_ew = 1'b0;
      wait_phase(3'd3, 300, "mid_walk_ew");
      checks++;
      if ({walk_ew, ew_g, remain} !== {2'b11, 6'd7}) begin
         failures++;
         $display("FAIL ew_walk_grant: walk/g=%b remain=%0d want 11 / 7",
                  {walk_ew, ew_g}, remain);
      end
      repeat (15) step();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk_ns, walk_ew, ped_wait_ns, ped_wait_ew,
           phase, remain} !== {10'b100_100_0000, 3'd5, 6'd1}) begin
         failures++;
         $display("FAIL async_reset: got %b phase=%0d remain=%0d want 1001000000 5 1",
                  {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk_ns, walk_ew, ped_wait_ns, ped_wait_ew},
                  phase, remain);
      end
   endtask

`ifdef EMERG_PREEMPT_EN
   // Preempt NS_GREEN at remain=3, hold EMERG 100 clk, then recover.
   task automatic test_emergency();
      int   cnt;
      logic hold_ok;
      emerg_req = 1'b0;
      do_reset();
      wait_phase(3'd0, 50, "emerg_ns");
      cnt = 0;
      while (remain !== 6'd3 && cnt < 100) begin
         step();
         cnt++;
      end
      emerg_req = 1'b1;
      step();
      checks++;
      if ({phase, remain, ns_y} !== {3'd1, 6'd2, 1'b1}) begin
         failures++;
         $display("FAIL emerg_preempt: phase=%0d remain=%0d ns_y=%b want 1/2/1",
                  phase, remain, ns_y);
      end
      wait_phase(3'd2, 40, "emerg_ar_a");
      cnt = 0;
      while (phase === 3'd2 && cnt < 50) begin
         cnt++;
         step();
      end
      checks++;
      if (cnt !== 10) begin
         failures++;
         $display("FAIL emerg_ar_len: got %0d clk want 10", cnt);
      end
      checks++;
      if ({phase, remain, ns_r, ew_r, walk_ns, walk_ew} !== {3'd6, 6'd0, 4'b1100}) begin
         failures++;
         $display("FAIL emerg_entry: phase=%0d remain=%0d r=%b walk=%b want 6/0/11/00",
                  phase, remain, {ns_r, ew_r}, {walk_ns, walk_ew});
      end
      hold_ok = 1'b1;
      for (int i = 1; i < 100; i++) begin
         step();
         if ({phase, remain, ns_r, ew_r} !== {3'd6, 6'd0, 2'b11}) hold_ok = 1'b0;
      end
      checks++;
      if (hold_ok !== 1'b1) begin
         failures++;
         $display("FAIL emerg_hold: left EMERG while emerg_req high, phase=%0d", phase);
      end
      emerg_req = 1'b0;
      step();
      checks++;
      if ({phase, remain} !== {3'd5, 6'd1}) begin
         failures++;
         $display("FAIL emerg_exit: phase=%0d remain=%0d want 5/1", phase, remain);
      end
      cnt = 0;
      while (phase === 3'd5 && cnt < 50) begin
         cnt++;
         step();
      end
      checks++;
      if ({cnt, phase, remain} !== {32'd10, 3'd0, 6'd5}) begin
         failures++;
         $display("FAIL emerg_recover: ar_len=%0d phase=%0d remain=%0d want 10/0/5",
                  cnt, phase, remain);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_normal_cycle(1'b0, "cycle");
      test_ped_between();
      test_ped_during_green();
      test_reset_mid_walk();
`ifdef EMERG_PREEMPT_EN
      test_emergency();
`else
      test_normal_cycle(1'b1, "cycle_emerg_ignored");
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
